seg_dynamic_display: RTL and testbench
======================================

Name: seg_dynamic_display

Overview:
- Consumer side of the price/display interface driven by the meter's data generator.
- Takes `data` (20-bit binary value), `point`, `sign` and `seg_en`.
- Converts `data` to BCD with a sequential shift-add-3 engine and drives a 6-digit common-anode 7-segment display by time-multiplexed scanning.
- Sits between the meter core and the board's digit-select and segment pins.

Parameters:
- CNT_MAX, 16'd49_999, scan counter terminal value; one digit slot lasts CNT_MAX+1 clocks (1 ms at 50 MHz).

Ports:
- sys_clk, input, 1, system clock.
- sys_rst_n, input, 1, asynchronous active-low reset.
- data, input, 20, unsigned value to display (price).
- point, input, 6, point[i]=1 lights the decimal point of digit i.
- sign, input, 1, 1 = show a minus sign.
- seg_en, input, 1, 1 = display on.
- sel, output, 6, digit select, active-low; sel[i] drives digit i; digit 0 is rightmost.
- seg, output, 8, segments, active-low; seg[7]=dp, seg[6:0]=g,f,e,d,c,b,a.

Behaviour:
- Clock and reset: one clock, sys_clk; reset sys_rst_n is asynchronous, active-low.
- Reset values:
  - sel=6'b111111, seg=8'hFF.
  - Scan counter=0, digit index=0.
  - Conversion FSM in S_LOAD.
  - Display registers: BCD=0, point=0, sign=0.
- Conversion FSM (runs continuously, period 22 clocks):
  - S_LOAD: capture data into a 20-bit shift register. If data>999_999, load 999_999 (clamp). Also capture point and sign, clear the 24-bit BCD accumulator, clear bit counter. Go to S_SHIFT.
  - S_SHIFT: each clock, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by one. After the 20th shift go to S_UPD.
  - S_UPD: copy the six BCD nibbles, captured point and captured sign into the display registers. Go to S_LOAD.
  - Display registers change only in S_UPD, so a new data value is visible at most 44 clocks after it is applied.
- Blanking, evaluated on the display registers:
  - H = index of the highest nonzero digit, or 0 if all digits are zero.
  - P = index of the highest set point bit, or 0 if none is set.
  - L = max(H, P).
  - Digits above L show blank (8'hFF). Digit 0 is never blanked.
- Sign:
  - If sign=1 and L<5, digit L+1 shows minus (8'hBF).
  - If L=5, the sign is dropped.
- Segment codes (dp off):
  - 0..4 = C0, F9, A4, B0, 99.
  - 5..9 = 92, 82, F8, 80, 90.
  - When point[i]=1 on a non-blank digit, bit 7 is cleared (e.g. 0 with dp = 8'h40).
  - The dp is never shown on blank or minus digits.
- Scan:
  - The scan counter counts 0..CNT_MAX and wraps to 0.
  - The digit index increments on wrap, 0→1→…→5→0.
  - sel and seg are registered from the current index and display registers: one clock latency after an index change, and both update on the same edge.
  - When seg_en=1: sel = ~(6'b1 << index), seg = code for digit index.
  - When seg_en=0: sel=6'b111111 and seg=8'hFF; the counter and index keep running.
- Reset mid-operation: all state returns to reset values immediately; the first S_UPD occurs 22 clocks after release.

Test Plan:
Benches use CNT_MAX=9.
1. data=8, sign=0, point=0, seg_en=1, run ≥6 slots after 44 clocks -> digit0 seg=8'h80; digits 1-5 seg=8'hFF; sel walks 3E,3D,3B,37,2F,1F.
2. data=123456 -> digits 5..0 = F9,A4,B0,99,92,82; sign=1 gives no minus (L=5).
3. data=0, then data=25 with sign=1 -> first digit0=C0, others FF; then digit1=A4, digit0=92, digit2=BF, digits 3-5 FF.
4. data=5, point=6'b000100 -> digit2=40, digit1=C0, digit0=92, digits 3-5 FF. Then data=20'hFFFFF -> all six digits 90 (clamp).
5. seg_en toggled 1→0→1 mid-slot -> sel=3F and seg=FF on the clock after the 0 is sampled; on return, scanning resumes at the uninterrupted index position.
6. Assert sys_rst_n low mid-conversion with data changing -> sel=3F and seg=FF asynchronously. After release, data=42 -> correct digits only after the first S_UPD (22 clocks); stale value never shown.

Source files
------------

// File: rtl/seg_dynamic_display_if.sv
// Price/display link between the meter's data generator and the 7-segment scanner.
// The master drives the value to show; the slave returns the digit-select and segment pins.
interface seg_dynamic_display_if;
   logic [19:0] data;
   logic [5:0]  point;
   logic        sign;
   logic        seg_en;
   logic [5:0]  sel;
   logic [7:0]  seg;

   modport master (output data, point, sign, seg_en, input sel, seg);
   modport slave  (input data, point, sign, seg_en, output sel, seg);
endinterface

// File: rtl/seg_dynamic_display.sv
// Binary-to-BCD conversion (shift-add-3) feeding a 6-digit common-anode scanner
// with leading-zero blanking, decimal points and a floating minus sign.
module seg_dynamic_display #(
   parameter logic [15:0] CNT_MAX = 16'd49_999
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   seg_dynamic_display_if.slave  bus
);
   typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_UPD} state_t;

   state_t      state_reg, state_next;
   logic        load_en, shift_en, upd_en;

   logic [19:0] bin_reg;
   logic [23:0] bcd_reg;
   logic [23:0] bcd_adj;
   logic [4:0]  bit_cnt_reg;
   logic [5:0]  cap_point_reg;
   logic        cap_sign_reg;

   logic [23:0] disp_bcd_reg;
   logic [5:0]  disp_point_reg;
   logic        disp_sign_reg;

   logic [15:0] cnt_reg;
   logic [2:0]  idx_reg;
   logic [5:0]  sel_reg;
   logic [7:0]  seg_reg;

   logic [5:0]  nz;
   logic [2:0]  hi_digit, hi_point, last_digit;
   logic [3:0]  cur_nib;
   logic [7:0]  seg_code;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_reg <= S_LOAD;
      else            state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_LOAD:  state_next = S_SHIFT;
         S_SHIFT: if (bit_cnt_reg == 5'd19) state_next = S_UPD;
         S_UPD:   state_next = S_LOAD;
         default: state_next = S_LOAD;
      endcase
   end

   always_comb begin
      load_en  = (state_reg == S_LOAD);
      shift_en = (state_reg == S_SHIFT);
      upd_en   = (state_reg == S_UPD);
   end

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_nib
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
         assign nz[gi] = |disp_bcd_reg[gi*4 +: 4];
      end
   endgenerate

   // Values beyond six digits saturate to all nines.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bin_reg       <= '0;
         bcd_reg       <= '0;
         bit_cnt_reg   <= '0;
         cap_point_reg <= '0;
         cap_sign_reg  <= 1'b0;
      end else if (load_en) begin
         bin_reg       <= (bus.data > 20'd999_999) ? 20'd999_999 : bus.data;
         bcd_reg       <= '0;
         bit_cnt_reg   <= '0;
         cap_point_reg <= bus.point;
         cap_sign_reg  <= bus.sign;
      end else if (shift_en) begin
         {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
         bit_cnt_reg        <= bit_cnt_reg + 5'd1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         disp_bcd_reg   <= '0;
         disp_point_reg <= '0;
         disp_sign_reg  <= 1'b0;
      end else if (upd_en) begin
         disp_bcd_reg   <= bcd_reg;
         disp_point_reg <= cap_point_reg;
         disp_sign_reg  <= cap_sign_reg;
      end
   end

   always_comb begin
      hi_digit = 3'd0;
      hi_point = 3'd0;
      for (int i = 0; i < 6; i++) begin
         if (nz[i])             hi_digit = 3'(i);
         if (disp_point_reg[i]) hi_point = 3'(i);
      end
      last_digit = (hi_digit > hi_point) ? hi_digit : hi_point;
   end

   assign cur_nib = disp_bcd_reg[{idx_reg, 2'b00} +: 4];

   // Above the last significant digit: blank, except one minus right after it.
   always_comb begin
      seg_code = 8'hFF;
      if (idx_reg > last_digit) begin
         if (disp_sign_reg && (idx_reg == last_digit + 3'd1)) seg_code = 8'hBF;
      end else begin
         case (cur_nib)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
         endcase
         seg_code[7] = ~disp_point_reg[idx_reg];
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_reg <= '0;
         idx_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
         cnt_reg <= '0;
         idx_reg <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
      end else begin
         cnt_reg <= cnt_reg + 16'd1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sel_reg <= 6'h3F;
         seg_reg <= 8'hFF;
      end else if (bus.seg_en) begin
         sel_reg <= ~(6'b000001 << idx_reg);
         seg_reg <= seg_code;
      end else begin
         sel_reg <= 6'h3F;
         seg_reg <= 8'hFF;
      end
   end

   assign bus.sel = sel_reg;
   assign bus.seg = seg_reg;
endmodule

// File: tb/tb_seg_dynamic_display.sv
// Directed bench: each pattern is checked digit by digit at the middle of every scan slot.
module tb_seg_dynamic_display;
   localparam logic [15:0] CNT = 16'd9;

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   int   cyc;
   int   n_checks = 0;
   int   n_pass = 0;

   seg_dynamic_display_if bus();

   seg_dynamic_display #(.CNT_MAX(CNT)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   always #5 sys_clk = ~sys_clk;

   // Posedges since reset release; slot k of the scan covers cyc 10k+1 .. 10k+10.
   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) cyc <= 0;
      else            cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %s: %h", tag, got);
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic apply(input logic [19:0] d, input logic [5:0] p, input logic s);
      @(negedge sys_clk);
      bus.data  = d;
      bus.point = p;
      bus.sign  = s;
      repeat (46) @(negedge sys_clk);
   endtask

   // exp holds {digit5, ..., digit0} segment codes.
   task automatic show(input string name, input logic [47:0] exp);
      int idx;
      logic [5:0] es;
      repeat (60) begin
         @(negedge sys_clk);
         if (cyc % 10 == 5) begin
            idx = ((cyc - 1) / 10) % 6;
            es  = ~(6'b000001 << idx);
            check($sformatf("%s sel d%0d", name, idx), {2'b00, bus.sel}, {2'b00, es});
            check($sformatf("%s seg d%0d", name, idx), bus.seg, exp[idx*8 +: 8]);
         end
      end
   endtask

   initial begin
      int idx;
      logic [5:0] es;
      bus.data   = '0;
      bus.point  = '0;
      bus.sign   = 1'b0;
      bus.seg_en = 1'b1;

      repeat (3) @(negedge sys_clk);
      check("reset sel", {2'b00, bus.sel}, 8'h3F);
      check("reset seg", bus.seg, 8'hFF);
      sys_rst_n = 1'b1;

      apply(20'd8, 6'b0, 1'b0);
      show("t1 data8", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80});

      apply(20'd123456, 6'b0, 1'b1);
      show("t2 123456", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});

      apply(20'd0, 6'b0, 1'b0);
      show("t3 zero", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});
      apply(20'd25, 6'b0, 1'b1);
      show("t3 -25", {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hA4, 8'h92});

      apply(20'd5, 6'b000100, 1'b0);
      show("t4 0.05", {8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'h92});
      apply(20'hFFFFF, 6'b0, 1'b0);
      show("t4 clamp", {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90});

      @(negedge sys_clk);
      bus.seg_en = 1'b0;
      @(negedge sys_clk);
      check("t5 off sel", {2'b00, bus.sel}, 8'h3F);
      check("t5 off seg", bus.seg, 8'hFF);
      repeat (15) @(negedge sys_clk);
      check("t5 held sel", {2'b00, bus.sel}, 8'h3F);
      bus.seg_en = 1'b1;
      @(negedge sys_clk);
      idx = ((cyc - 1) / 10) % 6;
      es  = ~(6'b000001 << idx);
      check("t5 resume sel", {2'b00, bus.sel}, {2'b00, es});

      @(negedge sys_clk);
      #2 bus.data = 20'd777;
      #1 sys_rst_n = 1'b0;
      #1;
      check("t6 async sel", {2'b00, bus.sel}, 8'h3F);
      check("t6 async seg", bus.seg, 8'hFF);
      repeat (2) @(negedge sys_clk);
      bus.data = 20'd42;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);
      check("t6 pre-upd sel", {2'b00, bus.sel}, 8'h3E);
      check("t6 pre-upd seg", bus.seg, 8'hC0);
      repeat (40) @(negedge sys_clk);
      show("t6 42", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h99, 8'hA4});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
